// File: rtl/pipearch_common.sv
// Shared CCI-P c0 channel types and helpers for the pipearch request fabric.
package pipearch_common;

  localparam int unsigned MAX_PORT_BITS = 2;

  localparam logic [3:0] eRSP_RDLINE = 4'h0;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef struct packed {
    t_ccip_clLen cl_len;
    logic [3:0]  req_type;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_cci_c0_ReqMemHdr;

  typedef struct packed {
    t_cci_c0_ReqMemHdr hdr;
    logic              valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        hit_miss;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_cci_c0_RspMemHdr;

  typedef struct packed {
    t_cci_c0_RspMemHdr hdr;
    logic [511:0]      data;
    logic              rspValid;
    logic              mmioRdValid;
    logic              mmioWrValid;
  } t_if_ccip_c0_Rx;

  function automatic logic [2:0] cl_len_lines(input t_ccip_clLen len);
    case (len)
      eCL_LEN_2: return 3'd2;
      eCL_LEN_4: return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

  function automatic logic cci_c0Rx_isReadRsp(input t_if_ccip_c0_Rx rx);
    return rx.rspValid && (rx.hdr.resp_type == eRSP_RDLINE);
  endfunction

endpackage

// File: rtl/pipearch_c0_req_queue.sv
// Show-ahead FIFO of c0 request headers; head is valid whenever o_empty is low.
module pipearch_c0_req_queue
  import pipearch_common::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  t_cci_c0_ReqMemHdr i_data,
  input  logic              i_pop,
  output t_cci_c0_ReqMemHdr o_head,
  output logic              o_empty,
  output logic [CntW-1:0]   o_count
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  t_cci_c0_ReqMemHdr r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_count;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CntW'(i_push) - CntW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/pipearch_c0_arbiter.sv
// Round-robin arbiter multiplexing NUM_PORTS c0 requesters onto one CCI-P c0 channel,
// tagging mdata[15:14] with the port index and routing read responses back by that tag.
module pipearch_c0_arbiter
  import pipearch_common::*;
#(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned MAX_INFLIGHT = 64,
  parameter int unsigned QUEUE_DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 c0TxAlmFull,
  input  t_if_ccip_c0_Rx       cp2af_sRx_c0,
  output t_if_ccip_c0_Tx       af2cp_sTx_c0,
  output logic [NUM_PORTS-1:0] port_c0TxAlmFull,
  input  t_if_ccip_c0_Tx       port_sTx_c0 [NUM_PORTS],
  output t_if_ccip_c0_Rx       port_sRx_c0 [NUM_PORTS]
);
  localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);

  t_cci_c0_ReqMemHdr          w_head [NUM_PORTS];
  logic [CntW-1:0]            w_count [NUM_PORTS];
  logic [NUM_PORTS-1:0]       w_empty, w_pop, w_elig, w_almfull_nxt;
  logic                       w_sel_valid, w_rd_rsp, w_rsp_ok;
  logic [MAX_PORT_BITS-1:0]   w_sel_idx, w_idx, w_rsp_tag;
  t_cci_c0_ReqMemHdr          w_sel_hdr;
  logic [31:0]                w_sum;
  logic [CntW-1:0]            w_cnt_nxt;
  logic [31:0]                w_inflight_nxt [NUM_PORTS];
  t_if_ccip_c0_Rx             w_rx_nxt [NUM_PORTS];

  logic [MAX_PORT_BITS-1:0]   r_rr_ptr;
  logic [31:0]                r_inflight [NUM_PORTS];
  t_if_ccip_c0_Tx             r_tx;
  t_if_ccip_c0_Rx             r_rx [NUM_PORTS];
  logic [NUM_PORTS-1:0]       r_almfull;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    pipearch_c0_req_queue #(
      .DEPTH(QUEUE_DEPTH)
    ) u_queue (
      .clk    (clk),
      .reset  (reset),
      .i_push (port_sTx_c0[i].valid),
      .i_data (port_sTx_c0[i].hdr),
      .i_pop  (w_pop[i]),
      .o_head (w_head[i]),
      .o_empty(w_empty[i]),
      .o_count(w_count[i])
    );
    assign w_pop[i] = w_sel_valid && (w_sel_idx == MAX_PORT_BITS'(i));
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_elig[i] = !w_empty[i] && !c0TxAlmFull &&
                  (({1'b0, r_inflight[i]} + 33'(cl_len_lines(w_head[i].cl_len)))
                   <= 33'(MAX_INFLIGHT));
    end
  end

  // Search starts one past the last winner so every port gets a turn.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    w_idx       = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      w_idx = MAX_PORT_BITS'((32'(r_rr_ptr) + k) % NUM_PORTS);
      if (!w_sel_valid && w_elig[w_idx]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = w_idx;
      end
    end
    w_sel_hdr = w_head[w_sel_idx];
    w_sel_hdr.mdata[15:14] = w_sel_idx;
  end

  always_comb begin
    w_rd_rsp  = cci_c0Rx_isReadRsp(cp2af_sRx_c0);
    w_rsp_tag = cp2af_sRx_c0.hdr.mdata[15:14];
    w_rsp_ok  = w_rd_rsp && (32'(w_rsp_tag) < NUM_PORTS);
    w_sum     = '0;
    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_sum = r_inflight[i] + (w_pop[i] ? 32'(cl_len_lines(w_head[i].cl_len)) : 32'd0);
      // A response against an empty count is still forwarded; only the count clamps.
      if (w_rsp_ok && (w_rsp_tag == MAX_PORT_BITS'(i)) && (w_sum != '0)) begin
        w_inflight_nxt[i] = w_sum - 32'd1;
      end else begin
        w_inflight_nxt[i] = w_sum;
      end

      w_rx_nxt[i] = cp2af_sRx_c0;
      if (w_rd_rsp) begin
        w_rx_nxt[i].hdr.mdata[15:14] = 2'b00;
        w_rx_nxt[i].rspValid = w_rsp_ok && (w_rsp_tag == MAX_PORT_BITS'(i));
      end else if (i != 0) begin
        w_rx_nxt[i].rspValid    = 1'b0;
        w_rx_nxt[i].mmioRdValid = 1'b0;
        w_rx_nxt[i].mmioWrValid = 1'b0;
      end

      w_cnt_nxt = w_count[i] + CntW'(port_sTx_c0[i].valid) - CntW'(w_pop[i]);
      w_almfull_nxt[i] = int'(w_cnt_nxt) >= int'(QUEUE_DEPTH) - 4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx      <= '0;
      r_rr_ptr  <= MAX_PORT_BITS'(NUM_PORTS - 1);
      r_almfull <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_inflight[i] <= '0;
        r_rx[i]       <= '0;
      end
    end else begin
      r_tx.valid <= w_sel_valid;
      r_tx.hdr   <= w_sel_valid ? w_sel_hdr : '0;
      if (w_sel_valid) r_rr_ptr <= w_sel_idx;
      r_almfull <= w_almfull_nxt;
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_inflight[i] <= w_inflight_nxt[i];
        r_rx[i]       <= w_rx_nxt[i];
      end
    end
  end

  assign af2cp_sTx_c0     = r_tx;
  assign port_c0TxAlmFull = r_almfull;
  assign port_sRx_c0      = r_rx;

endmodule

// File: tb/tb_pipearch_c0_arbiter.sv
// Scoreboard bench for pipearch_c0_arbiter: issued headers and routed responses are
// predicted at drive time and compared as the DUT emits them.
module tb_pipearch_c0_arbiter;
  import pipearch_common::*;

  localparam int NP = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 c0TxAlmFull;
  t_if_ccip_c0_Rx       cp2af_sRx_c0;
  t_if_ccip_c0_Tx       af2cp_sTx_c0;
  logic [NP-1:0]        port_c0TxAlmFull;
  t_if_ccip_c0_Tx       port_sTx_c0 [NP];
  t_if_ccip_c0_Rx       port_sRx_c0 [NP];

  typedef struct {
    int          port;
    logic [15:0] mdata;
    logic [31:0] data;
  } rx_exp_t;

  t_cci_c0_ReqMemHdr exp_tx [$];
  rx_exp_t           exp_rx [$];
  t_cci_c0_ReqMemHdr mon_h;
  rx_exp_t           mon_r;

  int n_checks = 0;
  int n_errors = 0;

  pipearch_c0_arbiter #(
    .NUM_PORTS   (NP),
    .MAX_INFLIGHT(64),
    .QUEUE_DEPTH (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .c0TxAlmFull     (c0TxAlmFull),
    .cp2af_sRx_c0    (cp2af_sRx_c0),
    .af2cp_sTx_c0    (af2cp_sTx_c0),
    .port_c0TxAlmFull(port_c0TxAlmFull),
    .port_sTx_c0     (port_sTx_c0),
    .port_sRx_c0     (port_sRx_c0)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [NP-1:0] rsp_vec();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = port_sRx_c0[p].rspValid;
    return v;
  endfunction

  task automatic clear_reqs();
    for (int p = 0; p < NP; p++) port_sTx_c0[p] = '0;
  endtask

  task automatic send_req(input int p, input t_ccip_clLen len, input logic [13:0] tag,
                          input bit expect_issue);
    t_cci_c0_ReqMemHdr h;
    h.cl_len   = len;
    h.req_type = 4'h0;
    h.address  = 42'(32'h1000 * (p + 1)) + 42'(tag);
    h.mdata    = {2'b00, tag};
    port_sTx_c0[p].valid = 1'b1;
    port_sTx_c0[p].hdr   = h;
    if (expect_issue) begin
      h.mdata[15:14] = 2'(p);
      exp_tx.push_back(h);
    end
  endtask

  task automatic clear_rsp();
    cp2af_sRx_c0 = '0;
  endtask

  // exp_port < 0 means the response must not appear anywhere.
  task automatic send_rsp(input logic [15:0] mdata, input logic [3:0] rtype, input int exp_port);
    rx_exp_t e;
    cp2af_sRx_c0                   = '0;
    cp2af_sRx_c0.rspValid          = 1'b1;
    cp2af_sRx_c0.hdr.resp_type     = rtype;
    cp2af_sRx_c0.hdr.mdata         = mdata;
    cp2af_sRx_c0.data              = {16{32'hD000_0000 | {16'h0, mdata}}};
    if (exp_port >= 0) begin
      e.port  = exp_port;
      e.mdata = (rtype == eRSP_RDLINE) ? {2'b00, mdata[13:0]} : mdata;
      e.data  = 32'hD000_0000 | {16'h0, mdata};
      exp_rx.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (af2cp_sTx_c0.valid === 1'b1) begin
      if (exp_tx.size() == 0) begin
        check_eq("tx_unexpected", 64'(af2cp_sTx_c0.valid), 64'd0);
      end else begin
        mon_h = exp_tx.pop_front();
        check_eq("tx_hdr", 64'(af2cp_sTx_c0.hdr), 64'(mon_h));
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (port_sRx_c0[p].rspValid === 1'b1) begin
        if (exp_rx.size() == 0) begin
          check_eq("rx_unexpected", 64'(port_sRx_c0[p].rspValid), 64'd0);
        end else begin
          mon_r = exp_rx.pop_front();
          check_eq("rx_port", 64'(p), 64'(mon_r.port));
          check_eq("rx_mdata", 64'(port_sRx_c0[p].hdr.mdata), 64'(mon_r.mdata));
          check_eq("rx_data", 64'(port_sRx_c0[p].data[31:0]), 64'(mon_r.data));
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    c0TxAlmFull = 1'b0;
    clear_reqs();
    clear_rsp();
    tick(3);
    check_eq("rst_tx_valid", 64'(af2cp_sTx_c0.valid), 64'd0);
    check_eq("rst_tx_hdr", 64'(af2cp_sTx_c0.hdr), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_vec()), 64'd0);
    check_eq("rst_almfull", 64'(port_c0TxAlmFull), 64'd0);
    reset = 1'b0;
    tick();

    // All four ports request together; issue order follows rr_ptr reset value.
    for (int p = 0; p < NP; p++) send_req(p, eCL_LEN_1, 14'(16 + p), 1'b1);
    tick();
    clear_reqs();
    for (int k = 0; k < NP; k++) begin
      tick();
      check_eq("rr_valid", 64'(af2cp_sTx_c0.valid), 64'd1);
      check_eq("rr_tag", 64'(af2cp_sTx_c0.hdr.mdata[15:14]), 64'(k));
    end
    tick(2);
    check_eq("rr_drained", 64'(exp_tx.size()), 64'd0);

    // Tagged read response to port 2.
    check_eq("rsp2_inflight_pre", 64'(dut.r_inflight[2]), 64'd1);
    send_rsp(16'h8005, eRSP_RDLINE, 2);
    tick();
    clear_rsp();
    check_eq("rsp2_vec", 64'(rsp_vec()), 64'b0100);
    check_eq("rsp2_mdata", 64'(port_sRx_c0[2].hdr.mdata), 64'h0005);
    check_eq("rsp2_inflight", 64'(dut.r_inflight[2]), 64'd0);
    for (int t = 0; t < NP; t++) begin
      if (t != 2) begin
        send_rsp({2'(t), 14'h11}, eRSP_RDLINE, t);
        tick();
        clear_rsp();
      end
    end
    tick();
    for (int t = 0; t < NP; t++) check_eq("inflight_clear", 64'(dut.r_inflight[t]), 64'd0);

    // Non-read traffic goes to port 0 untouched and never touches inflight.
    send_rsp(16'hC0DE, 4'h1, 0);
    tick();
    clear_rsp();
    check_eq("nonrd_vec", 64'(rsp_vec()), 64'b0001);
    check_eq("nonrd_mdata", 64'(port_sRx_c0[0].hdr.mdata), 64'hC0DE);
    check_eq("nonrd_inflight3", 64'(dut.r_inflight[3]), 64'd0);

    // Inflight limit: 16 x 4 lines fill port 2, the 17th waits for 4 responses.
    for (int n = 0; n < 16; n++) begin
      send_req(2, eCL_LEN_4, 14'(n), 1'b1);
      tick();
      clear_reqs();
    end
    send_req(2, eCL_LEN_4, 14'd16, 1'b1);
    tick();
    clear_reqs();
    tick(8);
    check_eq("lim_held", 64'(exp_tx.size()), 64'd1);
    check_eq("lim_inflight64", 64'(dut.r_inflight[2]), 64'd64);
    send_rsp({2'd2, 14'h20}, eRSP_RDLINE, 2);
    tick();
    clear_rsp();
    tick(6);
    check_eq("lim_held_63", 64'(exp_tx.size()), 64'd1);
    for (int n = 0; n < 3; n++) begin
      send_rsp({2'd2, 14'(33 + n)}, eRSP_RDLINE, 2);
      tick();
      clear_rsp();
    end
    tick(4);
    check_eq("lim_issued", 64'(exp_tx.size()), 64'd0);
    check_eq("lim_inflight_after", 64'(dut.r_inflight[2]), 64'd64);
    for (int n = 0; n < 64; n++) begin
      send_rsp({2'd2, 14'(64 + n)}, eRSP_RDLINE, 2);
      tick();
      clear_rsp();
    end
    tick();
    check_eq("lim_drained", 64'(dut.r_inflight[2]), 64'd0);

    // Shared almost-full blocks issue; per-port almost-full rises at 4 queued.
    c0TxAlmFull = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send_req(1, eCL_LEN_1, 14'(256 + k), 1'b1);
      tick();
      clear_reqs();
      check_eq("af_no_issue", 64'(af2cp_sTx_c0.valid), 64'd0);
      check_eq("af_port1", 64'(port_c0TxAlmFull[1]), (k >= 3) ? 64'd1 : 64'd0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("af_no_issue", 64'(af2cp_sTx_c0.valid), 64'd0);
    end
    c0TxAlmFull = 1'b0;
    tick(12);
    check_eq("af_all_issued", 64'(exp_tx.size()), 64'd0);
    check_eq("af_port1_clear", 64'(port_c0TxAlmFull[1]), 64'd0);
    for (int n = 0; n < 6; n++) begin
      send_rsp({2'd1, 14'(300 + n)}, eRSP_RDLINE, 1);
      tick();
      clear_rsp();
    end

    // Same-cycle issue (+2) and response (-1) on port 0 starting from 3.
    for (int n = 0; n < 3; n++) begin
      send_req(0, eCL_LEN_1, 14'(400 + n), 1'b1);
      tick();
      clear_reqs();
    end
    tick(4);
    check_eq("net_inflight3", 64'(dut.r_inflight[0]), 64'd3);
    send_req(0, eCL_LEN_2, 14'h200, 1'b1);
    tick();
    clear_reqs();
    check_eq("net_pre", 64'(dut.r_inflight[0]), 64'd3);
    send_rsp({2'd0, 14'h201}, eRSP_RDLINE, 0);
    tick();
    clear_rsp();
    check_eq("net_inflight4", 64'(dut.r_inflight[0]), 64'd4);
    tick(2);
    for (int n = 0; n < 4; n++) begin
      send_rsp({2'd0, 14'(500 + n)}, eRSP_RDLINE, 0);
      tick();
      clear_rsp();
    end

    // Reset with queued requests discards them; late response still routed.
    c0TxAlmFull = 1'b1;
    for (int n = 0; n < 5; n++) begin
      send_req(3, eCL_LEN_1, 14'(600 + n), 1'b0);
      tick();
      clear_reqs();
    end
    check_eq("rq_almfull3", 64'(port_c0TxAlmFull[3]), 64'd1);
    reset = 1'b1;
    tick(2);
    reset       = 1'b0;
    c0TxAlmFull = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("rq_no_issue", 64'(af2cp_sTx_c0.valid), 64'd0);
    end
    check_eq("rq_almfull_clear", 64'(port_c0TxAlmFull), 64'd0);
    check_eq("rq_inflight1_pre", 64'(dut.r_inflight[1]), 64'd0);
    send_rsp({2'd1, 14'h0ABC}, eRSP_RDLINE, 1);
    tick();
    clear_rsp();
    check_eq("rq_late_vec", 64'(rsp_vec()), 64'b0010);
    check_eq("rq_inflight1", 64'(dut.r_inflight[1]), 64'd0);

    tick(3);
    check_eq("end_tx_empty", 64'(exp_tx.size()), 64'd0);
    check_eq("end_rx_empty", 64'(exp_rx.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipearch_c0_arbiter.md
PIPEARCH_C0_ARBITER -- requirements
Module: pipearch_c0_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requester ports (legal range 1..4).
REQ-002 SHALL have parameter MAX_INFLIGHT, default 64, per-port limit on outstanding read lines.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 8, per-port request queue entries.
REQ-004 SHALL have port clk  in  1  clock; all logic on posedge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port c0TxAlmFull  in  1  shared-channel almost-full.
REQ-007 SHALL have port cp2af_sRx_c0  in  t_if_ccip_c0_Rx  shared response channel.
REQ-008 SHALL have port af2cp_sTx_c0  out  t_if_ccip_c0_Tx  shared request channel.
REQ-009 SHALL have port port_c0TxAlmFull  out  [NUM_PORTS] x 1  per-requester almost-full.
REQ-010 SHALL have port port_sTx_c0  in  [NUM_PORTS] x t_if_ccip_c0_Tx  per-requester requests.
REQ-011 SHALL have port port_sRx_c0  out  [NUM_PORTS] x t_if_ccip_c0_Rx  per-requester responses.

Function
REQ-012 SHALL enqueue each port_sTx_c0[i] with valid=1 into queue i in the same cycle; all ports may enqueue simultaneously, no request dropped.
REQ-013 SHALL assert port_c0TxAlmFull[i] (registered) when queue i holds >= QUEUE_DEPTH-4 entries; requesters may issue up to 4 more requests after assertion.
REQ-014 SHALL, per cycle, select at most one non-empty queue by round-robin starting at rr_ptr+1 (mod NUM_PORTS), then set rr_ptr to the selected index.
REQ-015 SHALL consider queue i eligible only if !c0TxAlmFull and inflight[i] + lines(head) <= MAX_INFLIGHT, with lines = 1/2/4 for eCL_LEN_1/2/4.
REQ-016 SHALL drive af2cp_sTx_c0 registered: one cycle after selection, valid=1, head header with mdata[15:14] replaced by port index; else valid=0, hdr=0.
REQ-017 SHALL require requesters to keep mdata[15:14]=0; lower 14 bits pass unchanged.
REQ-018 SHALL route each read response (cci_c0Rx_isReadRsp) to port mdata[15:14], registered, 1-cycle latency, with mdata[15:14] cleared and data unmodified; other ports get rspValid=0.
REQ-019 SHALL forward non-read c0 Rx traffic to port 0 unchanged, 1-cycle latency.
REQ-020 SHALL maintain inflight[i] (32-bit): + lines on issue, -1 per routed read response; same-cycle issue and response net both.
REQ-021 SHALL saturate inflight[i] at 0 on decrement; the response is still forwarded.
REQ-022 SHALL drop responses tagged with port index >= NUM_PORTS.
REQ-023 SHALL assume a full queue is never written (requester violation); overflow behaviour is undefined.

Reset
REQ-024 SHALL on reset: af2cp_sTx_c0.valid=0, hdr=0; all port_sRx_c0 rspValid=0; all port_c0TxAlmFull=0; rr_ptr=NUM_PORTS-1; inflight=0; queues emptied.
REQ-025 SHALL on reset mid-operation discard queued requests; responses arriving after reset are routed per REQ-018/REQ-021.

Structure
REQ-026 SHALL place MAX_PORT_BITS=2 and a cl_len-to-lines function in the shared pipearch_common package.
REQ-027 SHALL instantiate one sub-module, pipearch_c0_req_queue (show-ahead FIFO of t_cci_c0_ReqMemHdr, depth QUEUE_DEPTH, count output), per port.
REQ-028 SHALL be 120-400 lines of RTL, excluding the queue.

Verification
REQ-029 SHALL cover: ports 0..3 each send one eCL_LEN_1 request in cycle 0 -> issued in order 0,1,2,3 on cycles 1-4 with mdata[15:14]=0,1,2,3.
REQ-030 SHALL cover: port 2 issues 64 lines (16 x eCL_LEN_4), no responses -> 17th request held; one response to port 2 -> still held (63+4>64); after 4 responses -> issued.
REQ-031 SHALL cover: c0TxAlmFull=1 for 10 cycles while port 1 sends 6 requests -> no af2cp valid; port_c0TxAlmFull[1]=1 after 4 queued; all 6 issued after release.
REQ-032 SHALL cover: response mdata=16'h8005 -> port_sRx_c0[2].rspValid=1 next cycle, mdata=16'h0005, inflight[2] decremented.
REQ-033 SHALL cover: same-cycle issue of eCL_LEN_2 on port 0 and response to port 0 with inflight[0]=3 -> inflight[0]=4.
REQ-034 SHALL cover: reset with 5 queued requests -> no further af2cp valid; late response to port 1 with inflight=0 forwarded, inflight stays 0.
